// File: rtl/fmul_issue_queue.sv
// Credit-gated issue/retire wrapper around the fixed-latency fmul pipeline.
// Optional overflow trap (sticky flag that halts issue) enabled by FMUL_OVF_TRAP_EN.
module fmul_issue_queue #(
  parameter int unsigned NSTAGE = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAGW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     mul_x1,
  output logic [31:0]     mul_x2,
  input  logic [31:0]     mul_y,
  input  logic            mul_ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
`ifdef FMUL_OVF_TRAP_EN
  ,
  output logic            ovf_sticky
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IFL_W = $clog2(NSTAGE + 1);
  localparam int unsigned SUM_W = $clog2(DEPTH + NSTAGE + 1);

  logic [NSTAGE-1:0] track_vld;
  logic [TAGW-1:0]   track_tag [NSTAGE];
  logic [IFL_W-1:0]  inflight;

  logic [31:0]       mem_y   [DEPTH];
  logic              mem_ovf [DEPTH];
  logic [TAGW-1:0]   mem_tag [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic accept;
  logic push;
  logic pop;

  assign accept = in_valid & in_ready;
  assign push   = track_vld[NSTAGE-1];
  assign pop    = out_valid & out_ready;

  // Operands reach fmul only for accepted ops so idle slots carry zeros.
  assign mul_x1 = accept ? in_x1 : 32'd0;
  assign mul_x2 = accept ? in_x2 : 32'd0;

  // Tracking pipe mirrors fmul's latency: entry NSTAGE-1 retires this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      track_vld <= '0;
    end else begin
      track_vld[0] <= accept;
      for (int i = 1; i < NSTAGE; i++) begin
        track_vld[i] <= track_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    track_tag[0] <= in_tag;
    for (int i = 1; i < NSTAGE; i++) begin
      track_tag[i] <= track_tag[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      inflight = inflight + IFL_W'(track_vld[i]);
    end
  end

  // Result storage; a push can never find the FIFO full thanks to credit gating.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]   <= mul_y;
      mem_ovf[wr_ptr] <= mul_ovf;
      mem_tag[wr_ptr] <= track_tag[NSTAGE-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count != CNT_W'(DEPTH));
    end
  end

`ifdef FMUL_OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (push && mul_ovf) begin
      ovf_sticky <= 1'b1;
    end
  end
`endif

  // Every in-flight op already owns a FIFO slot, so credits = DEPTH - count - inflight.
  always_comb begin
    in_ready = !rst && ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
`ifdef FMUL_OVF_TRAP_EN
    if (ovf_sticky) in_ready = 1'b0;
`endif
  end

  assign out_valid = (count != '0);
  assign out_y     = mem_y[rd_ptr];
  assign out_ovf   = mem_ovf[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign busy      = (inflight != '0) || (count != '0);

endmodule
